// File: rtl/ram_arbiter.sv
// Registered request/acknowledge arbiter sharing one SDRAM byte port among DMA, tape, FDD and CPU.
// Optional CPU anti-starvation counter is enabled by defining RAM_ARB_ANTISTARVE_EN.
module ram_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int STARVE_MAX = 12
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [3:0]            req,
    input  logic [3:0]            req_we,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [31:0]           req_din,
    output logic [3:0]            ack,
    output logic [7:0]            rdata,
    output logic [3:0]            grant,
    output logic                  busy,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [7:0]            mem_din,
    output logic                  mem_rd,
    output logic                  mem_we,
    input  logic [7:0]            mem_dout,
    input  logic                  mem_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [3:0]          grant_q;
    logic [3:0]          ack_q;
    logic [7:0]          rdata_q;
    logic                busy_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          din_q;
    logic                we_q;
    logic                rd_stb_q;
    logic                wr_stb_q;
    logic                rr_fdd_q;

    logic                cpu_promote_s;
    logic [3:0]          sel_grant_s;
    logic [1:0]          sel_idx_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [7:0]          sel_din_s;
    logic                sel_we_s;

    // Winner selection: DMA first, optional CPU promotion, tape/FDD round-robin, CPU last.
    always_comb begin
        sel_grant_s = 4'b0000;
        if (req[0]) begin
            sel_grant_s = 4'b0001;
        end else if (cpu_promote_s && req[3]) begin
            sel_grant_s = 4'b1000;
        end else if (req[1] && req[2]) begin
            sel_grant_s = rr_fdd_q ? 4'b0100 : 4'b0010;
        end else if (req[1]) begin
            sel_grant_s = 4'b0010;
        end else if (req[2]) begin
            sel_grant_s = 4'b0100;
        end else if (req[3]) begin
            sel_grant_s = 4'b1000;
        end else begin
            sel_grant_s = 4'b0000;
        end
    end

    // Steer the winning port's address, data and direction onto the latch inputs.
    always_comb begin
        sel_idx_s = 2'd0;
        case (sel_grant_s)
            4'b0010: sel_idx_s = 2'd1;
            4'b0100: sel_idx_s = 2'd2;
            4'b1000: sel_idx_s = 2'd3;
            default: sel_idx_s = 2'd0;
        endcase
        sel_addr_s = req_addr[int'(sel_idx_s)*ADDR_W +: ADDR_W];
        sel_din_s  = req_din[int'(sel_idx_s)*8 +: 8];
        sel_we_s   = req_we[sel_idx_s];
    end

`ifdef RAM_ARB_ANTISTARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_q;
    logic [3:0] starve_d;

    assign cpu_promote_s = (starve_q >= STARVE_LIM);

    // Count tape/FDD wins the waiting CPU has lost; any CPU win or CPU idle clears it.
    always_comb begin
        starve_d = starve_q;
        if (!req[3]) begin
            starve_d = 4'd0;
        end else if (sel_grant_s[3]) begin
            starve_d = 4'd0;
        end else if ((sel_grant_s[1] || sel_grant_s[2]) && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter only advances on arbitration decisions taken in IDLE.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= 4'd0;
        end else if (state_q == S_IDLE) begin
            starve_q <= starve_d;
        end else begin
            starve_q <= starve_q;
        end
    end
`else
    assign cpu_promote_s = 1'b0;
`endif

    // Access sequencer: latch winner, one-cycle strobe, wait for sram, one-cycle ack.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            grant_q  <= 4'b0000;
            ack_q    <= 4'b0000;
            rdata_q  <= 8'h00;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            din_q    <= 8'h00;
            we_q     <= 1'b0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            rr_fdd_q <= 1'b0;
        end else begin
            ack_q    <= 4'b0000;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req != 4'b0000) begin
                        grant_q  <= sel_grant_s;
                        busy_q   <= 1'b1;
                        addr_q   <= sel_addr_s;
                        din_q    <= sel_din_s;
                        we_q     <= sel_we_s;
                        rd_stb_q <= ~sel_we_s;
                        wr_stb_q <= sel_we_s;
                        if (sel_grant_s[1] || sel_grant_s[2]) begin
                            rr_fdd_q <= ~rr_fdd_q;
                        end else begin
                            rr_fdd_q <= rr_fdd_q;
                        end
                        state_q <= S_ISSUE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A requester that withdrew mid-access is still acknowledged.
                    if (mem_done) begin
                        if (!we_q) begin
                            rdata_q <= mem_dout;
                        end else begin
                            rdata_q <= rdata_q;
                        end
                        ack_q   <= grant_q;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_DONE: begin
                    grant_q <= 4'b0000;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    grant_q <= 4'b0000;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign mem_rd   = rd_stb_q;
    assign mem_we   = wr_stb_q;

endmodule
